ah_lru_grant_tracker: RTL and testbench
=======================================

Name: ah_lru_grant_tracker

Overview:
Grant-consumer side of the LRU arbiter. Accepts the arbiter's one-hot grant and holds ownership of the shared resource for the granted requester until that requester signals completion or a hold timeout fires. While the resource is owned, it drives the gnt_busy mask back to the arbiter. It also reports the owner, protocol errors and a saturating grant count. It sits between the arbiter and the shared resource, one instance per arbitrated resource.

Parameters:
N, 8, number of requesters; widths of gnt, done and gnt_busy.
MAX_HOLD, 16, maximum cycles an owner may hold the resource; legal range 2..65535.
CNT_W, 16, width of the saturating grant counter.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
gnt  input  N  grant vector from the arbiter; legal values are zero or one-hot
done  input  N  per-requester completion pulse; one cycle, level-sampled
gnt_busy  output  N  resource-busy mask to the arbiter; all bits equal; 1 = blocked
owner_vld  output  1  a requester currently owns the resource
owner_oh  output  N  one-hot current owner; zero when owner_vld=0
owner_id  output  $clog2(N)  binary owner index; holds the last owner after release
timeout_err  output  1  one-cycle pulse: owner forcibly released
grant_err  output  1  one-cycle pulse: multi-hot gnt, or gnt while not IDLE
done_err  output  1  one-cycle pulse: done asserted by a non-owner, or done while not OWNED
grant_cnt  output  CNT_W  accepted-grant count, saturating

Behaviour:
- Reset (async, rst=1). Takes effect immediately, including mid-ownership:
  - state = IDLE
  - gnt_busy, owner_vld, owner_oh, owner_id, errors, grant_cnt and hold counter all = 0
- All outputs are registered.
- FSM states: IDLE, OWNED, DRAIN.
- IDLE:
  - gnt one-hot: capture owner_oh=gnt and owner_id=index; hold_cnt=0; grant_cnt++ (saturate at all-ones); go OWNED. owner_vld=1 and gnt_busy=all-ones from the next cycle, i.e. 1-cycle latency.
  - gnt multi-hot: grant_err pulse next cycle; stay IDLE; no capture.
  - Any done bit set: done_err pulse.
- OWNED:
  - hold_cnt increments each cycle; width $clog2(MAX_HOLD+1).
  - done[owner_id]=1: go DRAIN; owner_vld=0 and owner_oh=0 next cycle.
  - done from a non-owner (any other done bit): done_err pulse. If done[owner] is set in the same cycle, it is still honoured.
  - hold_cnt==MAX_HOLD-1 and done[owner]=0: timeout_err pulse; go DRAIN. The owner therefore holds for exactly MAX_HOLD cycles.
  - done[owner] and timeout in the same cycle: done wins; no timeout_err.
  - gnt nonzero: grant_err pulse; grant ignored; owner unchanged.
- DRAIN:
  - Exactly one cycle; gnt_busy still all-ones to cover arbiter grant-pipeline latency. Then IDLE, with gnt_busy=0 the following cycle.
  - gnt nonzero in DRAIN: grant_err pulse; ignored.
  - done nonzero in DRAIN: done_err pulse.
- gnt_busy timing: high from the cycle after acceptance through the DRAIN cycle inclusive.
- Minimum grant-to-grant spacing: 3 cycles (accept, >=1 OWNED, DRAIN).
- Error pulses are independent; several may assert in the same cycle.
- grant_cnt never wraps. It clears only on reset.

Test Plan:
1. Reset, then gnt=8'h04 for 1 cycle; done[2] 3 cycles later -> owner_vld=1, owner_id=2 and gnt_busy=8'hFF from cycle+1. owner_vld=0 the cycle after done. gnt_busy=0 two cycles after done. grant_cnt=1.
2. gnt=8'h01; no done -> timeout_err pulses after exactly MAX_HOLD=16 OWNED cycles; DRAIN; IDLE. done[0] on the timeout cycle instead -> no timeout_err.
3. gnt=8'h11 in IDLE -> grant_err=1 for one cycle; owner_vld stays 0; grant_cnt unchanged.
4. Owner 5 held; gnt=8'h02 and done=8'h08 in the same cycle -> grant_err=1 and done_err=1; owner_id stays 5; ownership continues.
5. Assert rst mid-OWNED (owner 7) -> all outputs 0 asynchronously. After release, gnt=8'h80 is accepted normally.
6. Force grant_cnt near all-ones (CNT_W=4 build); 20 accepted grants -> grant_cnt holds at 4'hF.

Source files
------------

// File: rtl/ah_lru_grant_tracker.sv
// ah_lru_grant_tracker: holds resource ownership for the granted requester until done or hold
// timeout, back-pressures the arbiter via gnt_busy and flags protocol errors.
module ah_lru_grant_tracker #(
   parameter int N        = 8,
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         gnt,
   input  logic [N-1:0]         done,
   output logic [N-1:0]         gnt_busy,
   output logic                 owner_vld,
   output logic [N-1:0]         owner_oh,
   output logic [$clog2(N)-1:0] owner_id,
   output logic                 timeout_err,
   output logic                 grant_err,
   output logic                 done_err,
   output logic [CNT_W-1:0]     grant_cnt
);
   localparam int IW = $clog2(N);
   localparam int HW = $clog2(MAX_HOLD + 1);

   typedef enum logic [1:0] {IDLE, OWNED, DRAIN} state_t;

   state_t          r_state, w_state_nxt;
   logic [HW-1:0]   r_hold, w_hold_nxt;
   logic [N-1:0]    r_busy, w_busy_nxt;
   logic [N-1:0]    r_oh, w_oh_nxt;
   logic [IW-1:0]   r_id, w_id_nxt, w_idx;
   logic            r_vld, w_vld_nxt;
   logic            r_tout, w_tout_nxt;
   logic            r_gerr, w_gerr_nxt;
   logic            r_derr, w_derr_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic            w_any, w_onehot, w_accept, w_own_done, w_timeout;

   always_comb begin
      w_idx = '0;
      for (int i = 0; i < N; i++)
         if (gnt[i]) w_idx = w_idx | IW'(i);
   end

   assign w_any      = |gnt;
   assign w_onehot   = w_any && ((gnt & (gnt - N'(1))) == '0);
   assign w_accept   = (r_state == IDLE) && w_onehot;
   assign w_own_done = (r_state == OWNED) && |(done & r_oh);
   assign w_timeout  = (r_state == OWNED) && (r_hold == HW'(MAX_HOLD - 1));

   always_ff @(posedge clk or posedge rst)
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;

   always_comb begin
      w_state_nxt = r_state;
      if (w_accept) w_state_nxt = OWNED;
      else if (w_own_done || w_timeout) w_state_nxt = DRAIN;
      else if (r_state == DRAIN) w_state_nxt = IDLE;
   end

   // Next values of the registered outputs; done[owner] beats a same-cycle timeout.
   always_comb begin
      w_busy_nxt = {N{w_state_nxt != IDLE}};
      w_vld_nxt  = (w_state_nxt == OWNED);
      w_oh_nxt   = w_accept ? gnt : (w_state_nxt == OWNED ? r_oh : '0);
      w_id_nxt   = w_accept ? w_idx : r_id;
      w_hold_nxt = w_accept ? '0 : (r_state == OWNED ? r_hold + HW'(1) : r_hold);
      w_tout_nxt = w_timeout && !w_own_done;
      w_gerr_nxt = w_any && (!w_onehot || r_state != IDLE);
      w_derr_nxt = (r_state == OWNED) ? |(done & ~r_oh) : |done;
      w_cnt_nxt  = (w_accept && r_cnt != '1) ? r_cnt + CNT_W'(1) : r_cnt;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_busy <= '0;
         r_vld  <= 1'b0;
         r_oh   <= '0;
         r_id   <= '0;
         r_hold <= '0;
         r_tout <= 1'b0;
         r_gerr <= 1'b0;
         r_derr <= 1'b0;
         r_cnt  <= '0;
      end else begin
         r_busy <= w_busy_nxt;
         r_vld  <= w_vld_nxt;
         r_oh   <= w_oh_nxt;
         r_id   <= w_id_nxt;
         r_hold <= w_hold_nxt;
         r_tout <= w_tout_nxt;
         r_gerr <= w_gerr_nxt;
         r_derr <= w_derr_nxt;
         r_cnt  <= w_cnt_nxt;
      end

   assign gnt_busy    = r_busy;
   assign owner_vld   = r_vld;
   assign owner_oh    = r_oh;
   assign owner_id    = r_id;
   assign timeout_err = r_tout;
   assign grant_err   = r_gerr;
   assign done_err    = r_derr;
   assign grant_cnt   = r_cnt;
endmodule

// File: tb/tb_ah_lru_grant_tracker.sv
// tb_ah_lru_grant_tracker: directed scenarios against hand-computed expectations; a second
// instance with a 4-bit counter shares the inputs to exercise saturation.
module tb_ah_lru_grant_tracker;
   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] gnt, done;
   logic [7:0] gnt_busy, owner_oh;
   logic       owner_vld, timeout_err, grant_err, done_err;
   logic [2:0] owner_id;
   logic [15:0] grant_cnt;
   logic [7:0] s_busy, s_oh;
   logic       s_vld, s_tout, s_gerr, s_derr;
   logic [2:0] s_id;
   logic [3:0] s_cnt;
   int errors = 0;
   int checks = 0;
   int exp_cnt = 0;
   int exp_sat = 0;

   ah_lru_grant_tracker #(.N(8), .MAX_HOLD(16), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .gnt(gnt), .done(done), .gnt_busy(gnt_busy),
      .owner_vld(owner_vld), .owner_oh(owner_oh), .owner_id(owner_id),
      .timeout_err(timeout_err), .grant_err(grant_err), .done_err(done_err),
      .grant_cnt(grant_cnt));

   ah_lru_grant_tracker #(.N(8), .MAX_HOLD(16), .CNT_W(4)) dut_sat (
      .clk(clk), .rst(rst), .gnt(gnt), .done(done), .gnt_busy(s_busy),
      .owner_vld(s_vld), .owner_oh(s_oh), .owner_id(s_id),
      .timeout_err(s_tout), .grant_err(s_gerr), .done_err(s_derr),
      .grant_cnt(s_cnt));

   always #5 clk = ~clk;

   task tick;
      @(negedge clk);
   endtask

   task test_reset;
      rst = 1'b1; gnt = '0; done = '0;
      repeat (2) tick();
      checks++; if (gnt_busy !== 8'h00) begin errors++; $display("FAIL rst_busy got=%h exp=00", gnt_busy); end
      checks++; if (owner_vld !== 1'b0) begin errors++; $display("FAIL rst_vld got=%b exp=0", owner_vld); end
      checks++; if (owner_id !== 3'd0) begin errors++; $display("FAIL rst_id got=%0d exp=0", owner_id); end
      checks++; if (grant_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt got=%0d exp=0", grant_cnt); end
      checks++; if ({timeout_err, grant_err, done_err} !== 3'b000) begin errors++; $display("FAIL rst_errs got=%b exp=000", {timeout_err, grant_err, done_err}); end
      rst = 1'b0;
      tick();
   endtask

   task test_grant_done;
      gnt = 8'h04; tick(); gnt = '0; exp_cnt++;
      checks++; if (owner_vld !== 1'b1) begin errors++; $display("FAIL gd_vld got=%b exp=1", owner_vld); end
      checks++; if (owner_id !== 3'd2) begin errors++; $display("FAIL gd_id got=%0d exp=2", owner_id); end
      checks++; if (owner_oh !== 8'h04) begin errors++; $display("FAIL gd_oh got=%h exp=04", owner_oh); end
      checks++; if (gnt_busy !== 8'hFF) begin errors++; $display("FAIL gd_busy got=%h exp=ff", gnt_busy); end
      checks++; if (grant_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL gd_cnt got=%0d exp=%0d", grant_cnt, exp_cnt); end
      tick(); tick(); done = 8'h04; tick(); done = '0;
      checks++; if (owner_vld !== 1'b0) begin errors++; $display("FAIL gd_rel_vld got=%b exp=0", owner_vld); end
      checks++; if (owner_oh !== 8'h00) begin errors++; $display("FAIL gd_rel_oh got=%h exp=00", owner_oh); end
      checks++; if (gnt_busy !== 8'hFF) begin errors++; $display("FAIL gd_drain_busy got=%h exp=ff", gnt_busy); end
      checks++; if (done_err !== 1'b0) begin errors++; $display("FAIL gd_derr got=%b exp=0", done_err); end
      tick();
      checks++; if (gnt_busy !== 8'h00) begin errors++; $display("FAIL gd_idle_busy got=%h exp=00", gnt_busy); end
      checks++; if (owner_id !== 3'd2) begin errors++; $display("FAIL gd_keep_id got=%0d exp=2", owner_id); end
   endtask

   task test_timeout;
      gnt = 8'h01; tick(); gnt = '0; exp_cnt++;
      repeat (15) tick();
      checks++; if (owner_vld !== 1'b1) begin errors++; $display("FAIL to_last_vld got=%b exp=1", owner_vld); end
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_early got=%b exp=0", timeout_err); end
      tick();
      checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_pulse got=%b exp=1", timeout_err); end
      checks++; if (owner_vld !== 1'b0) begin errors++; $display("FAIL to_vld got=%b exp=0", owner_vld); end
      checks++; if (gnt_busy !== 8'hFF) begin errors++; $display("FAIL to_drain_busy got=%h exp=ff", gnt_busy); end
      tick();
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_one_cycle got=%b exp=0", timeout_err); end
      checks++; if (gnt_busy !== 8'h00) begin errors++; $display("FAIL to_idle_busy got=%h exp=00", gnt_busy); end
      gnt = 8'h01; tick(); gnt = '0; exp_cnt++;
      repeat (15) tick();
      done = 8'h01; tick(); done = '0;
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_done_wins got=%b exp=0", timeout_err); end
      checks++; if (owner_vld !== 1'b0) begin errors++; $display("FAIL to_done_vld got=%b exp=0", owner_vld); end
      checks++; if (done_err !== 1'b0) begin errors++; $display("FAIL to_done_derr got=%b exp=0", done_err); end
      tick();
      checks++; if (gnt_busy !== 8'h00) begin errors++; $display("FAIL to_done_idle got=%h exp=00", gnt_busy); end
   endtask

   task test_multi_hot;
      gnt = 8'h11; done = 8'h40; tick(); gnt = '0; done = '0;
      checks++; if (grant_err !== 1'b1) begin errors++; $display("FAIL mh_gerr got=%b exp=1", grant_err); end
      checks++; if (done_err !== 1'b1) begin errors++; $display("FAIL mh_idle_derr got=%b exp=1", done_err); end
      checks++; if (owner_vld !== 1'b0) begin errors++; $display("FAIL mh_vld got=%b exp=0", owner_vld); end
      checks++; if (grant_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL mh_cnt got=%0d exp=%0d", grant_cnt, exp_cnt); end
      tick();
      checks++; if (grant_err !== 1'b0) begin errors++; $display("FAIL mh_one_cycle got=%b exp=0", grant_err); end
      checks++; if (gnt_busy !== 8'h00) begin errors++; $display("FAIL mh_busy got=%h exp=00", gnt_busy); end
   endtask

   task test_concurrent_err;
      gnt = 8'h20; tick(); exp_cnt++;
      gnt = 8'h02; done = 8'h08; tick(); gnt = '0;
      checks++; if ({grant_err, done_err} !== 2'b11) begin errors++; $display("FAIL ce_errs got=%b exp=11", {grant_err, done_err}); end
      checks++; if (owner_id !== 3'd5) begin errors++; $display("FAIL ce_id got=%0d exp=5", owner_id); end
      checks++; if (owner_vld !== 1'b1 || owner_oh !== 8'h20) begin errors++; $display("FAIL ce_own got=%b/%h exp=1/20", owner_vld, owner_oh); end
      done = 8'h28; tick(); done = '0;
      checks++; if (done_err !== 1'b1) begin errors++; $display("FAIL ce_mixed_derr got=%b exp=1", done_err); end
      checks++; if (owner_vld !== 1'b0 || grant_err !== 1'b0) begin errors++; $display("FAIL ce_mixed_rel got=%b/%b exp=0/0", owner_vld, grant_err); end
      tick();
      checks++; if (gnt_busy !== 8'h00) begin errors++; $display("FAIL ce_idle got=%h exp=00", gnt_busy); end
   endtask

   task test_async_reset;
      gnt = 8'h80; tick(); gnt = '0; exp_cnt++; exp_sat++;
      checks++; if (owner_id !== 3'd7 || owner_vld !== 1'b1) begin errors++; $display("FAIL ar_own got=%0d/%b exp=7/1", owner_id, owner_vld); end
      #2 rst = 1'b1;
      #1;
      exp_cnt = 0; exp_sat = 0;
      checks++; if (owner_vld !== 1'b0 || gnt_busy !== 8'h00) begin errors++; $display("FAIL ar_async got=%b/%h exp=0/00", owner_vld, gnt_busy); end
      checks++; if (owner_id !== 3'd0 || owner_oh !== 8'h00) begin errors++; $display("FAIL ar_owner got=%0d/%h exp=0/00", owner_id, owner_oh); end
      checks++; if (grant_cnt !== 16'd0 || s_cnt !== 4'd0) begin errors++; $display("FAIL ar_cnt got=%0d/%0d exp=0/0", grant_cnt, s_cnt); end
      tick(); rst = 1'b0;
      gnt = 8'h80; tick(); gnt = '0; exp_cnt++; exp_sat++;
      checks++; if (owner_id !== 3'd7 || owner_vld !== 1'b1) begin errors++; $display("FAIL ar_regrant got=%0d/%b exp=7/1", owner_id, owner_vld); end
      checks++; if (grant_cnt !== 16'(exp_cnt) || s_cnt !== 4'(exp_sat)) begin errors++; $display("FAIL ar_cnt1 got=%0d/%0d exp=%0d/%0d", grant_cnt, s_cnt, exp_cnt, exp_sat); end
      done = 8'h80; tick(); done = '0; tick();
   endtask

   task test_back_to_back;
      gnt = 8'h02; tick(); gnt = '0; exp_cnt++; exp_sat++;
      done = 8'h02; tick(); done = '0;
      gnt = 8'h04;
      checks++; if (gnt_busy !== 8'hFF || owner_vld !== 1'b0) begin errors++; $display("FAIL bb_drain got=%h/%b exp=ff/0", gnt_busy, owner_vld); end
      tick();
      checks++; if (grant_err !== 1'b1) begin errors++; $display("FAIL bb_drain_gerr got=%b exp=1", grant_err); end
      checks++; if (owner_vld !== 1'b0 || gnt_busy !== 8'h00) begin errors++; $display("FAIL bb_ignored got=%b/%h exp=0/00", owner_vld, gnt_busy); end
      checks++; if (grant_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL bb_cnt got=%0d exp=%0d", grant_cnt, exp_cnt); end
      gnt = 8'h08; tick(); gnt = '0; exp_cnt++; exp_sat++;
      checks++; if (owner_id !== 3'd3 || owner_vld !== 1'b1) begin errors++; $display("FAIL bb_next got=%0d/%b exp=3/1", owner_id, owner_vld); end
      done = 8'h08; tick(); done = '0; tick();
   endtask

   task test_saturation;
      for (int k = 0; k < 20; k++) begin
         gnt = 8'h01; tick(); gnt = '0;
         exp_cnt++;
         exp_sat = (exp_sat < 15) ? exp_sat + 1 : 15;
         checks++; if (s_cnt !== 4'(exp_sat)) begin errors++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", k, s_cnt, exp_sat); end
         done = 8'h01; tick(); done = '0; tick();
      end
      checks++; if (s_cnt !== 4'hF) begin errors++; $display("FAIL sat_final got=%h exp=f", s_cnt); end
      checks++; if (grant_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL sat_wide got=%0d exp=%0d", grant_cnt, exp_cnt); end
   endtask

   initial begin
      test_reset();
      test_grant_done();
      test_timeout();
      test_multi_hot();
      test_concurrent_err();
      test_async_reset();
      test_back_to_back();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
